// File: rtl/snap_capture_ctrl_pkg.sv
// Shared types and bit positions for the snapshot capture controller.
package snap_capture_pkg;

   typedef enum logic [1:0] {
      IDLE,
      ARMED,
      CAPTURE,
      DONE
   } state_t;

   localparam int CTRL_ARM       = 0;
   localparam int CTRL_TRIG_SEL  = 1;
   localparam int CTRL_VALID_SEL = 2;
   localparam int CTRL_ABORT     = 3;

   localparam int STAT_DONE = 31;
   localparam int STAT_BUSY = 30;

endpackage

// File: rtl/snap_capture_ctrl_if.sv
// Control/sample/BRAM bundle for snap_capture_ctrl.
// SNAP_CAPTURE_TIMESTAMP_EN adds the tstamp signal.
interface snap_capture_if #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 11
);
   logic [31:0]           ctrl;
   logic [DATA_WIDTH-1:0] din;
   logic                  din_valid;
   logic                  trig;
   logic [ADDR_WIDTH-1:0] bram_addr;
   logic [DATA_WIDTH-1:0] bram_din;
   logic                  bram_we;
   logic [31:0]           status;
`ifdef SNAP_CAPTURE_TIMESTAMP_EN
   logic [31:0]           tstamp;

   modport master (
      output ctrl, din, din_valid, trig,
      input  bram_addr, bram_din, bram_we, status, tstamp
   );

   modport slave (
      input  ctrl, din, din_valid, trig,
      output bram_addr, bram_din, bram_we, status, tstamp
   );
`else
   modport master (
      output ctrl, din, din_valid, trig,
      input  bram_addr, bram_din, bram_we, status
   );

   modport slave (
      input  ctrl, din, din_valid, trig,
      output bram_addr, bram_din, bram_we, status
   );
`endif
endinterface

// File: rtl/snap_capture_ctrl_wr_port.sv
// Registered BRAM write stage: one-cycle addr/data/we pipeline plus sample count.
module snap_capture_wr_port #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 11
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  clear,
   input  logic                  accept,
   input  logic [DATA_WIDTH-1:0] sample,
   output logic [ADDR_WIDTH:0]   count,
   output logic [ADDR_WIDTH-1:0] addr,
   output logic [DATA_WIDTH-1:0] data,
   output logic                  we
);

   // Accepted sample lands at the current count; data holds when idle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count <= '0;
         addr  <= '0;
         data  <= '0;
         we    <= 1'b0;
      end else begin
         we <= 1'b0;
         if (clear) begin
            count <= '0;
         end else if (accept) begin
            addr  <= count[ADDR_WIDTH-1:0];
            data  <= sample;
            we    <= 1'b1;
            count <= count + 1'b1;
         end
      end
   end

endmodule

// File: rtl/snap_capture_ctrl.sv
// Snapshot capture controller: arm/trigger/abort FSM driving one BRAM capture.
// SNAP_CAPTURE_TIMESTAMP_EN adds a free-running cycle counter and tstamp.
module snap_capture_ctrl
   import snap_capture_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 11
) (
   input logic           user_clk,
   input logic           user_rst,
   snap_capture_if.slave bus
);

   localparam logic [ADDR_WIDTH:0] LAST_ADDR = {1'b0, {ADDR_WIDTH{1'b1}}};

   state_t state, state_next;
   logic arm_q, arm_rise, acc, eff_trig, abort;
   logic accept, clear, set_done, done, busy;
   logic [ADDR_WIDTH:0] count;
   logic ctrl_unused;

   assign arm_rise    = bus.ctrl[CTRL_ARM] & ~arm_q;
   assign acc         = bus.ctrl[CTRL_VALID_SEL] ? bus.din_valid : 1'b1;
   assign eff_trig    = bus.ctrl[CTRL_TRIG_SEL] ? bus.trig : 1'b1;
   assign abort       = bus.ctrl[CTRL_ABORT];
   assign busy        = (state == ARMED) || (state == CAPTURE);
   assign ctrl_unused = ^bus.ctrl[31:4];

   always_ff @(posedge user_clk or posedge user_rst) begin
      if (user_rst) begin
         state <= IDLE;
         arm_q <= 1'b0;
         done  <= 1'b0;
      end else begin
         state <= state_next;
         arm_q <= bus.ctrl[CTRL_ARM];
         if (clear) begin
            done <= 1'b0;
         end else if (set_done) begin
            done <= 1'b1;
         end
      end
   end

   // Abort outranks a re-arm, which outranks any sample acceptance.
   always_comb begin
      state_next = state;
      accept     = 1'b0;
      clear      = 1'b0;
      set_done   = 1'b0;
      if (abort) begin
         state_next = IDLE;
      end else if (arm_rise) begin
         state_next = ARMED;
         clear      = 1'b1;
      end else begin
         case (state)
            ARMED: begin
               if (acc && eff_trig) begin
                  accept     = 1'b1;
                  state_next = CAPTURE;
               end
            end
            CAPTURE: begin
               if (acc) begin
                  accept = 1'b1;
                  if (count == LAST_ADDR) begin
                     state_next = DONE;
                     set_done   = 1'b1;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   snap_capture_wr_port #(
      .DATA_WIDTH(DATA_WIDTH),
      .ADDR_WIDTH(ADDR_WIDTH)
   ) u_wr_port (
      .clk   (user_clk),
      .rst   (user_rst),
      .clear (clear),
      .accept(accept),
      .sample(bus.din),
      .count (count),
      .addr  (bus.bram_addr),
      .data  (bus.bram_din),
      .we    (bus.bram_we)
   );

   always_comb begin
      bus.status                 = '0;
      bus.status[STAT_DONE]      = done;
      bus.status[STAT_BUSY]      = busy;
      bus.status[ADDR_WIDTH:0]   = count;
   end

`ifdef SNAP_CAPTURE_TIMESTAMP_EN
   logic [31:0] cycle_cnt;

   // Timestamp latches the free-running count on the trigger sample only.
   always_ff @(posedge user_clk or posedge user_rst) begin
      if (user_rst) begin
         cycle_cnt  <= '0;
         bus.tstamp <= '0;
      end else begin
         cycle_cnt <= cycle_cnt + 1'b1;
         if (accept && (state == ARMED)) begin
            bus.tstamp <= cycle_cnt;
         end
      end
   end
`endif

endmodule

// File: tb/tb_snap_capture_ctrl.sv
// Scoreboard bench for snap_capture_ctrl with a 16-deep capture.
module tb_snap_capture_ctrl;

   localparam int DW = 32;
   localparam int AW = 4;

   typedef struct {
      int            cyc;
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
   } exp_t;

   logic user_clk = 1'b0;
   logic user_rst = 1'b1;
   int   cyc = 0;
   int   rst_edges = 0;
   int   n_cmp = 0;
   int   n_err = 0;
   exp_t sb[$];

   snap_capture_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

   snap_capture_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
      .user_clk(user_clk),
      .user_rst(user_rst),
      .bus     (bus)
   );

   always #5 user_clk = ~user_clk;

   always @(posedge user_clk) begin
      cyc       <= cyc + 1;
      rst_edges <= user_rst ? 0 : rst_edges + 1;
   end

   task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("[TB] FAIL %s: got %08h, expected %08h (cycle %0d)", tag, act, exp, cyc);
      end
   endtask

   // One cycle of stimulus; an expected write is due in the following cycle.
   task automatic applyStimulus(input logic [31:0] c, input logic dv, input logic tr,
                                input bit exp_w, input int exp_a);
      logic [DW-1:0] d;
      exp_t e;
      d             = $urandom;
      bus.ctrl      = c;
      bus.din       = d;
      bus.din_valid = dv;
      bus.trig      = tr;
      if (exp_w) begin
         e.cyc  = cyc + 1;
         e.addr = exp_a[AW-1:0];
         e.data = d;
         sb.push_back(e);
      end
      @(posedge user_clk);
      #1;
   endtask

   always @(negedge user_clk) begin
      exp_t e;
      logic exp_we;
      exp_we = (sb.size() > 0) && (sb[0].cyc == cyc);
      checkOutput("bram_we", 32'(bus.bram_we), 32'(exp_we));
      if (exp_we) begin
         e = sb.pop_front();
         checkOutput("bram_addr", 32'(bus.bram_addr), 32'(e.addr));
         checkOutput("bram_din", bus.bram_din, e.data);
      end
   end

   initial begin
      bus.ctrl      = '0;
      bus.din       = '0;
      bus.din_valid = 1'b0;
      bus.trig      = 1'b0;
      repeat (2) @(posedge user_clk);
      checkOutput("rst_status", bus.status, 32'h0);
      checkOutput("rst_addr", 32'(bus.bram_addr), 32'h0);
      checkOutput("rst_din", bus.bram_din, 32'h0);
      @(negedge user_clk);
      #1 user_rst = 1'b0;
      @(posedge user_clk);
      #1;

      // Immediate, ungated: 16 writes, first two cycles after the arm edge
      applyStimulus(32'h0, 1'b0, 1'b0, 0, 0);
      applyStimulus(32'h1, 1'b0, 1'b0, 0, 0);
      checkOutput("t1_armed", bus.status, 32'h4000_0000);
      for (int i = 0; i < 16; i++) begin
         applyStimulus(32'h1, 1'b0, 1'b0, 1, i);
         if (i == 0) checkOutput("t1_first", bus.status, 32'h4000_0001);
      end
      checkOutput("t1_done", bus.status, 32'h8000_0010);
      for (int i = 0; i < 3; i++) applyStimulus(32'h1, 1'b1, 1'b1, 0, 0);
      checkOutput("t1_hold", bus.status, 32'h8000_0010);

      // External trigger: pre-trigger samples discarded, trig ignored afterwards
      applyStimulus(32'h0, 1'b0, 1'b0, 0, 0);
      applyStimulus(32'h3, 1'b0, 1'b0, 0, 0);
      checkOutput("t2_armed", bus.status, 32'h4000_0000);
      for (int i = 0; i < 6; i++) applyStimulus(32'h3, 1'b1, 1'b0, 0, 0);
      applyStimulus(32'h3, 1'b0, 1'b1, 1, 0);
      for (int i = 1; i < 16; i++) applyStimulus(32'h3, 1'b0, 1'b0, 1, i);
      checkOutput("t2_done", bus.status, 32'h8000_0010);

      // Valid-gated with din_valid alternating 1010...
      applyStimulus(32'h0, 1'b0, 1'b0, 0, 0);
      applyStimulus(32'h5, 1'b0, 1'b0, 0, 0);
      for (int i = 0; i < 32; i++) begin
         applyStimulus(32'h5, (i % 2) == 0, 1'b0, (i % 2) == 0, i / 2);
         if (i == 15) checkOutput("t3_mid", bus.status, 32'h4000_0008);
      end
      checkOutput("t3_done", bus.status, 32'h8000_0010);

      // Abort at count 7, then re-arm, then restart mid-capture
      applyStimulus(32'h0, 1'b0, 1'b0, 0, 0);
      applyStimulus(32'h1, 1'b0, 1'b0, 0, 0);
      for (int i = 0; i < 7; i++) applyStimulus(32'h1, 1'b0, 1'b0, 1, i);
      checkOutput("t4_count7", bus.status, 32'h4000_0007);
      applyStimulus(32'h9, 1'b0, 1'b0, 0, 0);
      checkOutput("t4_abort", bus.status, 32'h0000_0007);
      for (int i = 0; i < 2; i++) applyStimulus(32'h9, 1'b0, 1'b0, 0, 0);
      applyStimulus(32'h0, 1'b0, 1'b0, 0, 0);
      checkOutput("t4_held", bus.status, 32'h0000_0007);
      applyStimulus(32'h1, 1'b0, 1'b0, 0, 0);
      checkOutput("t4_rearm", bus.status, 32'h4000_0000);
      applyStimulus(32'h1, 1'b0, 1'b0, 1, 0);
      applyStimulus(32'h1, 1'b0, 1'b0, 1, 1);
      applyStimulus(32'h0, 1'b0, 1'b0, 1, 2);
      applyStimulus(32'h1, 1'b0, 1'b0, 0, 0);
      checkOutput("t4_restart", bus.status, 32'h4000_0000);
      for (int i = 0; i < 16; i++) applyStimulus(32'h1, 1'b0, 1'b0, 1, i);
      checkOutput("t4_done", bus.status, 32'h8000_0010);

      // Arm edge together with abort while ARMED: abort wins, held arm cannot re-arm
      applyStimulus(32'h0, 1'b0, 1'b0, 0, 0);
      applyStimulus(32'h3, 1'b0, 1'b0, 0, 0);
      applyStimulus(32'h2, 1'b0, 1'b0, 0, 0);
      checkOutput("t5_armed", bus.status, 32'h4000_0000);
      applyStimulus(32'hB, 1'b0, 1'b1, 0, 0);
      checkOutput("t5_abort", bus.status, 32'h0);
      for (int i = 0; i < 4; i++) applyStimulus(32'h3, 1'b1, 1'b1, 0, 0);
      checkOutput("t5_noarm", bus.status, 32'h0);

      // Asynchronous reset in the middle of a capture
      applyStimulus(32'h0, 1'b0, 1'b0, 0, 0);
      applyStimulus(32'h1, 1'b0, 1'b0, 0, 0);
      for (int i = 0; i < 5; i++) applyStimulus(32'h1, 1'b0, 1'b0, 1, i);
      @(negedge user_clk);
      #1 user_rst = 1'b1;
      bus.ctrl = '0;
      #1;
      checkOutput("ar_status", bus.status, 32'h0);
      checkOutput("ar_we", 32'(bus.bram_we), 32'h0);
      checkOutput("ar_addr", 32'(bus.bram_addr), 32'h0);
      checkOutput("ar_din", bus.bram_din, 32'h0);
`ifdef SNAP_CAPTURE_TIMESTAMP_EN
      checkOutput("ar_tstamp", bus.tstamp, 32'h0);
`endif
      @(negedge user_clk);
      #1 user_rst = 1'b0;
      @(posedge user_clk);
      #1;

      // Post-reset capture; trigger cycle count feeds the timestamp check
      applyStimulus(32'h3, 1'b0, 1'b0, 0, 0);
      for (int i = 0; i < 3; i++) applyStimulus(32'h3, 1'b1, 1'b0, 0, 0);
      begin
         int exp_ts;
         exp_ts = rst_edges;
         applyStimulus(32'h3, 1'b0, 1'b1, 1, 0);
`ifdef SNAP_CAPTURE_TIMESTAMP_EN
         checkOutput("tstamp", bus.tstamp, 32'(exp_ts));
`endif
         for (int i = 1; i < 16; i++) applyStimulus(32'h3, 1'b0, 1'b1, 1, i);
`ifdef SNAP_CAPTURE_TIMESTAMP_EN
         checkOutput("tstamp_hold", bus.tstamp, 32'(exp_ts));
`endif
      end
      checkOutput("t6_done", bus.status, 32'h8000_0010);
      applyStimulus(32'h0, 1'b0, 1'b0, 0, 0);
      applyStimulus(32'h0, 1'b0, 1'b0, 0, 0);

      checkOutput("sb_pending", 32'(sb.size()), 32'h0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
